// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
//   Types and constants shared by the PLL reset sequencer files.
//   pll_state_t : sequencer FSM state, also driven on the debug state port
//   MAX_NUM_CE  : upper limit on the number of clock-enable channels
package pll_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } pll_state_t;

   localparam int MAX_NUM_CE = 8;

endpackage

// File: rtl/ce_divider.sv
// ce_divider
//   One clock-enable channel. While run is high, a counter steps 0..div-1.
//   The ce output is high on the cycle the counter holds div-1, and the counter
//   then wraps to 0. A divisor of 0 or 1 gives a strobe on every run cycle.
//   When run is low, ce is forced low in that same cycle and the counter
//   restarts from 0.
// Ports
//   clock_in : PLL output clock
//   reset_n  : asynchronous active-low reset
//   run      : channel enable (sequencer in RUN)
//   div      : divisor, held stable by the sequencer for the whole RUN
//   ce       : one-cycle clock-enable strobe
module ce_divider #(
   parameter int CNT_W = 16
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             run,
   input  logic [CNT_W-1:0] div,
   output logic             ce
);

   logic [CNT_W-1:0] cnt;
   logic             term;

   // Testing div <= 1 first keeps div-1 from underflowing when div is 0.
   assign term = (div <= CNT_W'(1)) || (cnt == div - CNT_W'(1));
   assign ce   = run & term;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (!run || term) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Synchronises the raw PLL lock flag and waits until lock has been stable.
//   It then holds the downstream reset for a fixed time before releasing it.
//   While running, it generates NUM_CE divided clock-enable strobes.
//   On loss of lock it re-asserts the reset and restarts the sequence.
// Ports
//   clock_in      : PLL output clock, the only clock of the block
//   reset_n       : asynchronous active-low reset
//   pll_locked    : raw PLL lock flag, asynchronous to clock_in
//   div_cfg       : channel i divisor at [i*CNT_W +: CNT_W]; latched on RUN entry
//   rst_out_n     : synchronous active-low reset for downstream logic
//   ready         : high while in RUN
//   ce            : clock-enable strobes, one per channel
//   state         : current FSM state (debug)
//   lock_loss_cnt : saturating count of lock losses in RUN
//                   (present only with LOCK_LOSS_CNT_EN defined)
// Build option: define LOCK_LOSS_CNT_EN to add the lock_loss_cnt port and its counter.
//
// state     | meaning
// WAIT_LOCK | waiting for the synchronised lock flag
// STABLE    | counting LOCK_WAIT consecutive locked cycles
// HOLD      | lock stable, holding rst_out_n low for RST_HOLD cycles
// RUN       | reset released, clock enables active
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int NUM_CE    = 2,
   parameter int CNT_W     = 16,
   parameter int LOCK_WAIT = 1024,
   parameter int RST_HOLD  = 16
) (
   input  logic                    clock_in,
   input  logic                    reset_n,
   input  logic                    pll_locked,
   input  logic [NUM_CE*CNT_W-1:0] div_cfg,
   output logic                    rst_out_n,
   output logic                    ready,
   output logic [NUM_CE-1:0]       ce,
   output logic [1:0]              state
`ifdef LOCK_LOSS_CNT_EN
   ,
   output logic [7:0]              lock_loss_cnt
`endif
);

   // The shared counter is cleared on every state entry, so it only ever
   // needs to reach the larger of the two terminal counts.
   localparam int MAXV = (LOCK_WAIT > RST_HOLD) ? LOCK_WAIT : RST_HOLD;
   localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
   localparam logic [CW-1:0] LW_LAST = CW'(LOCK_WAIT - 1);
   localparam logic [CW-1:0] RH_LAST = CW'(RST_HOLD - 1);

   pll_state_t              st;
   logic [CW-1:0]           cnt;
   logic                    lk_meta;
   logic                    lk_s;
   logic [NUM_CE*CNT_W-1:0] div_q;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         lk_meta <= 1'b0;
         lk_s    <= 1'b0;
      end else begin
         lk_meta <= pll_locked;
         lk_s    <= lk_meta;
      end
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         st        <= WAIT_LOCK;
         cnt       <= '0;
         rst_out_n <= 1'b0;
         ready     <= 1'b0;
         div_q     <= '0;
`ifdef LOCK_LOSS_CNT_EN
         lock_loss_cnt <= 8'd0;
`endif
      end else begin
         case (st)
            WAIT_LOCK: begin
               if (lk_s) begin
                  st  <= STABLE;
                  cnt <= '0;
               end
            end
            STABLE: begin
               if (!lk_s) begin
                  st <= WAIT_LOCK;
               end else if (cnt == LW_LAST) begin
                  st  <= HOLD;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (!lk_s) begin
                  st <= WAIT_LOCK;
               end else if (cnt == RH_LAST) begin
                  st        <= RUN;
                  div_q     <= div_cfg;
                  rst_out_n <= 1'b1;
                  ready     <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               if (!lk_s) begin
                  st        <= WAIT_LOCK;
                  rst_out_n <= 1'b0;
                  ready     <= 1'b0;
`ifdef LOCK_LOSS_CNT_EN
                  if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 1'b1;
`endif
               end
            end
            default: st <= WAIT_LOCK;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
      ce_divider #(.CNT_W(CNT_W)) u_div (
         .clock_in (clock_in),
         .reset_n  (reset_n),
         .run      (st == RUN),
         .div      (div_q[i*CNT_W +: CNT_W]),
         .ce       (ce[i])
      );
   end

   assign state = st;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer.
// The reference model tracks how many consecutive cycles the synchronised lock
// flag has been high and derives the expected phase from that run length.
// It also tracks the number of cycles spent in RUN, which gives the expected
// strobe pattern.
module tb_pll_reset_sequencer;

   localparam int NUM_CE = 2;
   localparam int CNT_W  = 16;
`ifdef LOCK_LOSS_CNT_EN
   localparam int LW = 32;
`else
   localparam int LW = 1024;
`endif
   localparam int RH = 16;

   logic                    clock_in = 1'b0;
   logic                    reset_n;
   logic                    pll_locked;
   logic [NUM_CE*CNT_W-1:0] div_cfg;
   logic                    rst_out_n;
   logic                    ready;
   logic [NUM_CE-1:0]       ce;
   logic [1:0]              state;
`ifdef LOCK_LOSS_CNT_EN
   logic [7:0]              lock_loss_cnt;
`endif

   pll_reset_sequencer #(
      .NUM_CE(NUM_CE), .CNT_W(CNT_W), .LOCK_WAIT(LW), .RST_HOLD(RH)
   ) dut (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .pll_locked (pll_locked),
      .div_cfg    (div_cfg),
      .rst_out_n  (rst_out_n),
      .ready      (ready),
      .ce         (ce),
      .state      (state)
`ifdef LOCK_LOSS_CNT_EN
      ,
      .lock_loss_cnt (lock_loss_cnt)
`endif
   );

   always #5 clock_in = ~clock_in;

   int checks = 0;
   int errors = 0;

   // model state
   bit m_s1 = 1'b0, m_s2 = 1'b0;
   int m_n = 0;
   int m_r = 0;
   int m_d [NUM_CE];
   int m_loss = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic int exp_state();
      if (m_n == 0)       return 0;
      if (m_n <= LW)      return 1;
      if (m_n <= LW + RH) return 2;
      return 3;
   endfunction

   task automatic compare_all();
      logic [NUM_CE-1:0] ev;
      bit run;
      run = (exp_state() == 3);
      for (int i = 0; i < NUM_CE; i++)
         ev[i] = run && (m_d[i] <= 1 || (m_r % m_d[i]) == 0);
      chk("state", 32'(state), 32'(exp_state()));
      chk("rst_out_n", 32'(rst_out_n), 32'(run));
      chk("ready", 32'(ready), 32'(run));
      chk("ce", 32'(ce), 32'(ev));
`ifdef LOCK_LOSS_CNT_EN
      chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
`endif
   endtask

   task automatic tick();
      int prev;
      @(posedge clock_in);
      if (!reset_n) begin
         m_s1 = 0; m_s2 = 0; m_n = 0; m_r = 0; m_loss = 0;
      end else begin
         prev = exp_state();
         if (m_s2) m_n++; else m_n = 0;
         m_s2 = m_s1;
         m_s1 = pll_locked;
         if (m_n == LW + RH + 1)
            for (int i = 0; i < NUM_CE; i++) m_d[i] = int'(div_cfg[i*CNT_W +: CNT_W]);
         if (exp_state() == 3) m_r++; else m_r = 0;
         if (prev == 3 && exp_state() == 0 && m_loss < 255) m_loss++;
      end
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      m_s1 = 0; m_s2 = 0; m_n = 0; m_r = 0; m_loss = 0;
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_rst_out_n", 32'(rst_out_n), 0);
      chk("rst_ce", 32'(ce), 0);
      chk("rst_ready", 32'(ready), 0);
      repeat (2) tick();
      reset_n = 1'b1;
   endtask

   initial begin
      int c;
      for (int i = 0; i < NUM_CE; i++) m_d[i] = 0;
      pll_locked = 1'b1;
      div_cfg    = {16'd4, 16'd1};
      do_reset();

      // lock held from reset release: latency to RUN
      c = 0;
      while (state != 2'd3 && c < LW + RH + 20) begin
         tick();
         c++;
      end
      chk("run_latency", 32'(c), 32'(LW + RH + 3));

      // ce[0] every cycle, ce[1] every 4th
      repeat (40) tick();

      // divisor change during RUN is ignored until next RUN entry
      div_cfg = {16'd8, 16'd1};
      repeat (20) tick();

      // lock loss: reset re-asserted within 3 cycles
      pll_locked = 1'b0;
      repeat (3) tick();
      chk("drop_rst_out_n", 32'(rst_out_n), 0);
      chk("drop_ce", 32'(ce), 0);
      repeat (5) tick();

      // relock: full sequence, new divisor 8 applies
      pll_locked = 1'b1;
      repeat (LW + RH + 40) tick();
      pll_locked = 1'b0;
      repeat (6) tick();

      // short lock pulse never leaves STABLE
      pll_locked = 1'b1;
      repeat (LW / 2) tick();
      chk("pulse_state", 32'(state), 1);
      pll_locked = 1'b0;
      repeat (10) tick();

      // randomized lock/divisor sequences
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < NUM_CE; i++) div_cfg[i*CNT_W +: CNT_W] = 16'($urandom_range(0, 9));
         pll_locked = 1'b1;
         c = int'($urandom_range(LW / 2, LW + RH + 60));
         for (int j = 0; j < c; j++) begin
            if ($urandom_range(0, 99) == 0) div_cfg[CNT_W +: CNT_W] = 16'($urandom_range(0, 9));
            tick();
         end
         pll_locked = 1'b0;
         repeat ($urandom_range(1, 6)) tick();
         if (k == 5) begin
            pll_locked = 1'b1;
            repeat ($urandom_range(3, LW + RH + 10)) tick();
            do_reset();
         end
      end

`ifdef LOCK_LOSS_CNT_EN
      do_reset();
      for (int k = 0; k < 300; k++) begin
         pll_locked = 1'b1;
         repeat (LW + RH + 5) tick();
         pll_locked = 1'b0;
         repeat (4) tick();
      end
      chk("loss_saturated", 32'(lock_loss_cnt), 255);
      do_reset();
      chk("loss_cleared", 32'(lock_loss_cnt), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

endmodule
